// File: rtl/arb_pkg.sv
// Shared types and constants for the IF/data memory port arbiter.
// Also hosts the width defaults that the pipeline constants header supplies elsewhere.
package arb_pkg;

    localparam int PC_SIZE    = 32;
    localparam int REG_SIZE   = 32;
    localparam int PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        ARB_PORT_IF,
        ARB_PORT_D
    } arb_port_e;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/arb_perf_counters.sv
// Saturating grant/conflict counters for the memory port arbiter.
// Only instantiated when ARB_PERF_EN is defined.
module arb_perf_counters
    import arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_grant,
    input  logic                  d_grant,
    input  logic                  conflict,
    output logic [PERF_CNT_W-1:0] if_grants,
    output logic [PERF_CNT_W-1:0] d_grants,
    output logic [PERF_CNT_W-1:0] conflicts
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_grants <= '0;
            d_grants  <= '0;
            conflicts <= '0;
        end else begin
            if (if_grant) if_grants <= sat_inc(if_grants);
            if (d_grant)  d_grants  <= sat_inc(d_grants);
            if (conflict) conflicts <= sat_inc(conflicts);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data port.
// Data wins by default; fetch is forced through after STARVE_MAX lost rounds.
// Define ARB_PERF_EN to build the grant/conflict performance counters.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = PC_SIZE,
    parameter int DATA_W     = REG_SIZE,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ack,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_rw,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic                  mem_rw,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [PERF_CNT_W-1:0] perf_if_grants,
    output logic [PERF_CNT_W-1:0] perf_d_grants,
    output logic [PERF_CNT_W-1:0] perf_conflicts
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);

    arb_state_t  state_q, state_d;
    arb_port_e   winner_q, winner_d;
    logic [3:0]  starve_q, starve_d;
    logic [2:0]  lat_q, lat_d;
    logic        mem_en_d, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, d_rdata_d;

    logic any_req, d_wins;

    assign any_req = if_req | d_req;
    // A starved fetch overrides data priority only when both are asking.
    assign d_wins  = d_req && !(if_req && (starve_q == STARVE_LIM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            winner_q  <= ARB_PORT_IF;
            starve_q  <= '0;
            lat_q     <= '0;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            starve_q  <= starve_d;
            lat_q     <= lat_d;
            mem_en    <= mem_en_d;
            mem_rw    <= mem_rw_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        starve_d    = starve_q;
        lat_d       = lat_q;
        mem_en_d    = mem_en;
        mem_rw_d    = mem_rw;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;

        case (state_q)
            ARB_IDLE: begin
                mem_en_d = 1'b0;
                if (any_req) begin
                    mem_en_d = 1'b1;
                    state_d  = ARB_ISSUE;
                    if (d_wins) begin
                        winner_d    = ARB_PORT_D;
                        mem_rw_d    = d_rw;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        if (if_req && (starve_q < STARVE_LIM))
                            starve_d = starve_q + 4'd1;
                    end else begin
                        winner_d    = ARB_PORT_IF;
                        mem_rw_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        starve_d    = '0;
                    end
                end
            end
            ARB_ISSUE: begin
                mem_en_d = 1'b0;
                lat_d    = LAT_INIT;
                state_d  = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (lat_q == '0) begin
                    if (winner_q == ARB_PORT_IF) if_rdata_d = mem_rdata;
                    else                         d_rdata_d  = mem_rw ? '0 : mem_rdata;
                    state_d = ARB_RESP;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Acks are decoded from registered state, so reset clears them at once.
    assign if_ack = (state_q == ARB_RESP) && (winner_q == ARB_PORT_IF);
    assign d_ack  = (state_q == ARB_RESP) && (winner_q == ARB_PORT_D);

`ifdef ARB_PERF_EN
    logic if_grant, d_grant, conflict;

    assign if_grant = (state_q == ARB_IDLE) && any_req && !d_wins;
    assign d_grant  = (state_q == ARB_IDLE) && d_wins;
    assign conflict = (state_q == ARB_IDLE) && if_req && d_req;

    arb_perf_counters u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_grant  (if_grant),
        .d_grant   (d_grant),
        .conflict  (conflict),
        .if_grants (perf_if_grants),
        .d_grants  (perf_d_grants),
        .conflicts (perf_conflicts)
    );
`else
    assign perf_if_grants = '0;
    assign perf_d_grants  = '0;
    assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=1 instance plus a MEM_LAT=3 instance.
// Expected acks are queued at stimulus time and checked when an ack appears.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        if_req, if_ack, d_req, d_rw, d_ack;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_rw;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] perf_if_grants, perf_d_grants, perf_conflicts;

    logic        if_req3, if_ack3, d_ack3;
    logic [31:0] if_addr3, if_rdata3, d_rdata3;
    logic        mem_en3, mem_rw3;
    logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;
    logic [31:0] p3_if, p3_d, p3_c;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t sb_e;
    logic        sb_port;
    logic [31:0] sb_data;

    logic        iss_en, iss_rw;
    logic [31:0] iss_addr, iss_wdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
        .perf_conflicts(perf_conflicts)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
        .d_req(1'b0), .d_rw(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ack(d_ack3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_rw(mem_rw3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
        .perf_if_grants(p3_if), .perf_d_grants(p3_d), .perf_conflicts(p3_c)
    );

    // Memory models: read data valid MEM_LAT edges after the sampling edge, junk otherwise.
    logic [31:0] mem1 [logic [31:0]];
    logic [31:0] mem3 [logic [31:0]];
    logic [31:0] rd1 = 32'h0;
    logic [31:0] rd3_0 = 32'h0, rd3_1 = 32'h0, rd3_2 = 32'h0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rw) begin
                mem1[mem_addr] = mem_wdata;
                rd1 <= 32'hBAD0_0001;
            end else begin
                rd1 <= mem1.exists(mem_addr) ? mem1[mem_addr] : 32'h0;
            end
        end else begin
            rd1 <= 32'hBAD0_0000;
        end
    end
    assign mem_rdata = rd1;

    always @(posedge clk) begin
        if (mem_en3 && !mem_rw3) rd3_0 <= mem3.exists(mem_addr3) ? mem3[mem_addr3] : 32'h0;
        else                     rd3_0 <= 32'hBAD0_0003;
        rd3_1 <= rd3_0;
        rd3_2 <= rd3_1;
    end
    assign mem_rdata3 = rd3_2;

    // Scoreboard: every ack on the main instance must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (if_ack || d_ack)) begin
            total++;
            if (if_ack && d_ack) begin
                bad++;
                $display("FAIL sb_one_ack: if_ack=%0b d_ack=%0b, need exactly one", if_ack, d_ack);
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_ack: if_ack=%0b d_ack=%0b with nothing outstanding", if_ack, d_ack);
            end else begin
                sb_e    = exp_q.pop_front();
                sb_port = d_ack;
                sb_data = d_ack ? d_rdata : if_rdata;
                if (sb_port !== sb_e.port || sb_data !== sb_e.data) begin
                    bad++;
                    $display("FAIL sb_ack: port=%0d data=%h, need port=%0d data=%h",
                             sb_port, sb_data, sb_e.port, sb_e.data);
                end
            end
        end
    end

    // Drives one request, snapshots the ISSUE cycle, scrambles inputs after grant, waits for ack.
    task automatic issue(input logic port, input logic rw, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat);
        lat = -1;
        @(negedge clk);
        if (port) begin
            d_req = 1'b1; d_rw = rw; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                iss_en = mem_en; iss_rw = mem_rw; iss_addr = mem_addr; iss_wdata = mem_wdata;
                if_addr = ~addr; d_addr = ~addr; d_wdata = ~wdata; d_rw = ~rw;
            end
            if (if_ack || d_ack) begin
                lat = k;
                break;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        if_req = 0; d_req = 0; d_rw = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
        if_req3 = 0; if_addr3 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (mem_en !== 1'b0)    begin bad++; $display("FAIL rst_mem_en: got %b need 0", mem_en); end
        total++; if (mem_rw !== 1'b0)    begin bad++; $display("FAIL rst_mem_rw: got %b need 0", mem_rw); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr: got %h need 0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata: got %h need 0", mem_wdata); end
        total++; if (if_ack !== 1'b0)    begin bad++; $display("FAIL rst_if_ack: got %b need 0", if_ack); end
        total++; if (d_ack !== 1'b0)     begin bad++; $display("FAIL rst_d_ack: got %b need 0", d_ack); end
        total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL rst_if_rdata: got %h need 0", if_rdata); end
        total++; if (d_rdata !== 32'h0)  begin bad++; $display("FAIL rst_d_rdata: got %h need 0", d_rdata); end
        total++; if (perf_conflicts !== 32'h0) begin bad++; $display("FAIL rst_perf: got %0d need 0", perf_conflicts); end
        rst_n = 1'b1;
    endtask

    task automatic test_if_read;
        int lat;
        exp_q.push_back('{port: 1'b0, data: 32'h8C22_0004});
        issue(1'b0, 1'b0, 32'h40, 32'h0, lat);
        total++; if (iss_en !== 1'b1)     begin bad++; $display("FAIL ifrd_mem_en: got %b need 1", iss_en); end
        total++; if (iss_addr !== 32'h40) begin bad++; $display("FAIL ifrd_mem_addr: got %h need 40", iss_addr); end
        total++; if (iss_rw !== 1'b0)     begin bad++; $display("FAIL ifrd_mem_rw: got %b need 0", iss_rw); end
        total++; if (lat !== 3)           begin bad++; $display("FAIL ifrd_latency: got %0d need 3", lat); end
        total++; if (if_rdata !== 32'h8C22_0004) begin bad++; $display("FAIL ifrd_rdata: got %h need 8c220004", if_rdata); end
        @(negedge clk);
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL ifrd_idle_en: got %b need 0", mem_en); end
    endtask

    task automatic test_d_write_read;
        int lat;
        exp_q.push_back('{port: 1'b1, data: 32'h0});
        issue(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, lat);
        total++; if (iss_rw !== 1'b1)            begin bad++; $display("FAIL dwr_mem_rw: got %b need 1", iss_rw); end
        total++; if (iss_addr !== 32'h100)       begin bad++; $display("FAIL dwr_mem_addr: got %h need 100", iss_addr); end
        total++; if (iss_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dwr_mem_wdata: got %h need deadbeef", iss_wdata); end
        total++; if (lat !== 3)                  begin bad++; $display("FAIL dwr_latency: got %0d need 3", lat); end
        total++; if (d_rdata !== 32'h0)          begin bad++; $display("FAIL dwr_rdata: got %h need 0", d_rdata); end
        total++; if (if_rdata !== 32'h8C22_0004) begin bad++; $display("FAIL dwr_if_hold: got %h need 8c220004", if_rdata); end
        exp_q.push_back('{port: 1'b1, data: 32'hDEAD_BEEF});
        issue(1'b1, 1'b0, 32'h100, 32'h0, lat);
        total++; if (d_rdata !== 32'hDEAD_BEEF)  begin bad++; $display("FAIL drd_rdata: got %h need deadbeef", d_rdata); end
    endtask

    task automatic test_back_to_back;
        int t1, gap;
        t1 = -1; gap = -1;
        exp_q.push_back('{port: 1'b0, data: 32'h8C22_0004});
        exp_q.push_back('{port: 1'b0, data: 32'h8C22_0004});
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (if_ack) begin t1 = k; break; end
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (if_ack) begin gap = k; break; end
        end
        if_req = 1'b0;
        total++; if (t1 !== 3)  begin bad++; $display("FAIL b2b_first: got %0d need 3", t1); end
        total++; if (gap !== 4) begin bad++; $display("FAIL b2b_gap: got %0d need 4", gap); end
    endtask

    task automatic test_conflict;
        int n;
        logic [31:0] pi, pd, pc;
        pi = perf_if_grants; pd = perf_d_grants; pc = perf_conflicts;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) exp_q.push_back('{port: 1'b0, data: 32'hA5A5_0200});
            else                  exp_q.push_back('{port: 1'b1, data: 32'h5A5A_0300});
        end
        @(negedge clk);
        if_addr = 32'h200; d_addr = 32'h300; d_rw = 1'b0; d_wdata = 32'h0;
        if_req = 1'b1; d_req = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if (if_ack || d_ack) n++;
        end
        if_req = 1'b0; d_req = 1'b0;
        total++; if (n !== 10) begin bad++; $display("FAIL conflict_acks: got %0d need 10", n); end
`ifdef ARB_PERF_EN
        total++; if (perf_if_grants - pi !== 32'd2)  begin bad++; $display("FAIL perf_if: got %0d need 2", perf_if_grants - pi); end
        total++; if (perf_d_grants - pd !== 32'd8)   begin bad++; $display("FAIL perf_d: got %0d need 8", perf_d_grants - pd); end
        total++; if (perf_conflicts - pc !== 32'd10) begin bad++; $display("FAIL perf_conf: got %0d need 10", perf_conflicts - pc); end
`else
        total++; if (perf_if_grants !== 32'd0) begin bad++; $display("FAIL perf_if_off: got %0d need 0 (start %0d)", perf_if_grants, pi); end
        total++; if (perf_d_grants !== 32'd0)  begin bad++; $display("FAIL perf_d_off: got %0d need 0 (start %0d)", perf_d_grants, pd); end
        total++; if (perf_conflicts !== 32'd0) begin bad++; $display("FAIL perf_conf_off: got %0d need 0 (start %0d)", perf_conflicts, pc); end
`endif
    endtask

    task automatic test_reset_mid;
        int seen, lat;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rmid_mem_en: got %b need 0", mem_en); end
        total++; if (if_ack !== 1'b0) begin bad++; $display("FAIL rmid_if_ack: got %b need 0", if_ack); end
        total++; if (d_ack !== 1'b0)  begin bad++; $display("FAIL rmid_d_ack: got %b need 0", d_ack); end
        total++; if (perf_if_grants !== 32'h0) begin bad++; $display("FAIL rmid_perf: got %0d need 0", perf_if_grants); end
        if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (if_ack || d_ack) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rmid_no_ack: got %0d acks need 0", seen); end
        exp_q.push_back('{port: 1'b0, data: 32'h8C22_0004});
        issue(1'b0, 1'b0, 32'h40, 32'h0, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL rmid_reissue: got %0d need 3", lat); end
    endtask

    task automatic test_lat3;
        int lat;
        logic en1, en2, dack;
        lat = -1; en1 = 0; en2 = 1; dack = 0;
        @(negedge clk);
        if_req3 = 1'b1; if_addr3 = 32'h80;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin en1 = mem_en3; if_addr3 = 32'hFFFF_FF7F; end
            if (k == 2) en2 = mem_en3;
            if (d_ack3) dack = 1'b1;
            if (if_ack3) begin lat = k; break; end
        end
        if_req3 = 1'b0;
        total++; if (lat !== 5)     begin bad++; $display("FAIL lat3_latency: got %0d need 5", lat); end
        total++; if (en1 !== 1'b1)  begin bad++; $display("FAIL lat3_en_issue: got %b need 1", en1); end
        total++; if (en2 !== 1'b0)  begin bad++; $display("FAIL lat3_en_wait: got %b need 0", en2); end
        total++; if (dack !== 1'b0) begin bad++; $display("FAIL lat3_d_ack: got %b need 0", dack); end
        total++; if (if_rdata3 !== 32'h1234_5678) begin bad++; $display("FAIL lat3_rdata: got %h need 12345678", if_rdata3); end
    endtask

    initial begin
        mem1[32'h40]  = 32'h8C22_0004;
        mem1[32'h200] = 32'hA5A5_0200;
        mem1[32'h300] = 32'h5A5A_0300;
        mem3[32'h80]  = 32'h1234_5678;
        test_reset();
        test_if_read();
        test_d_write_read();
        test_back_to_back();
        test_conflict();
        test_reset_mid();
        test_lat3();
        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d outstanding need 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port `memory` instance between the instruction-fetch (IF) requester and the data (MEM-stage) requester of the 5-stage pipeline.
- Uses a per-port req/ack handshake, registered memory-side outputs and a fixed memory read latency.
- Data port has priority, with a starvation guard for fetch.
- Sits between the pipeline stages and the memory; the pipeline stalls on a missing ack.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- MEM_LAT, 1, cycles from the memory sampling mem_en until mem_rdata is valid (legal range 1..4).
- STARVE_MAX, 4, consecutive lost IF arbitrations before IF is forced to win (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; if_rdata is valid this cycle.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held until d_ack.
- d_rw  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  read data; 0 for writes.
- mem_en  out  1  memory enable (registered).
- mem_rw  out  1  memory write select (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data.
- perf_if_grants  out  32  IF grant count (only with ARB_PERF_EN).
- perf_d_grants  out  32  data grant count (only with ARB_PERF_EN).
- perf_conflicts  out  32  count of cycles where both requests were seen in IDLE (only with ARB_PERF_EN).

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - state = IDLE.
  - mem_en, mem_rw, if_ack, d_ack = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - starve_cnt = 0, lat_cnt = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE, mem_en = 0.
  - Any request: pick a winner; register mem_addr, mem_rw, mem_wdata (0 for IF) from the winner; set mem_en = 1; go to ISSUE.
- Arbitration:
  - Only d_req high: D wins.
  - Only if_req high: IF wins.
  - Both high: D wins unless starve_cnt == STARVE_MAX, in which case IF wins.
- starve_cnt:
  - +1 when IF requests and loses.
  - Cleared when IF is granted.
  - Saturates at STARVE_MAX.
- ISSUE (one cycle; the memory samples the request at the closing edge):
  - mem_en is deasserted at the closing edge.
  - lat_cnt = MEM_LAT − 1.
  - Go to WAIT.
- WAIT:
  - When lat_cnt == 0: capture mem_rdata into the winner's rdata register (0 for a write) and go to RESP.
  - Otherwise lat_cnt decrements.
- RESP:
  - The winner's ack is high for exactly one cycle.
  - Then go to IDLE.
- Latency: request seen at edge E0 → ack high in the cycle after edge E0+MEM_LAT+1. With MEM_LAT=1, ack is 3 cycles after req.
- Throughput: one transaction per MEM_LAT+3 cycles.
- Handshake rules:
  - A requester may drop req before it is granted (while state is IDLE); this is harmless.
  - After the grant, req/addr/data changes are ignored until the ack.
  - Any req high in the RESP cycle is sampled fresh in the following IDLE cycle, so back-to-back transactions from the same port are legal.
  - The non-granted port's rdata holds its last value.
  - Only one ack is high in any cycle.
- Reset mid-transaction:
  - Outstanding transaction is abandoned and no ack is issued.
  - mem_en drops immediately.
  - Requesters must reissue after reset.

Optional Feature:
- ARB_PERF_EN defined:
  - Three 32-bit saturating counters, cleared by rst_n.
  - perf_if_grants / perf_d_grants increment on each grant.
  - perf_conflicts increments on each IDLE cycle with both requests high.
- Undefined: perf_* ports are tied to 0 and no counter flops are built.

Decomposition:
- Package arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}.
  - arb_port_e {ARB_PORT_IF, ARB_PORT_D}.
  - PERF_CNT_W = 32.
- Width defaults come from the existing constants header (PC_SIZE, REG_SIZE).
- Sub-module arb_perf_counters holds the three saturating counters; instantiated only under ARB_PERF_EN.

Test Plan:
- IF-only read, if_addr=0x40, memory model returns 0x8C220004 → mem_en high one cycle with mem_addr=0x40; if_ack 3 cycles after req; if_rdata=0x8C220004.
- Data write, d_rw=1, d_addr=0x100, d_wdata=0xDEADBEEF → mem_rw=1, mem_wdata=0xDEADBEEF; d_ack at +3 cycles; d_rdata=0; a subsequent read of 0x100 returns 0xDEADBEEF.
- if_req and d_req both held continuously, STARVE_MAX=4 → grant order D,D,D,D,IF,D,D,D,D,IF; never both acks in one cycle.
- MEM_LAT=3, single IF read → ack at +5 cycles; rdata is sampled exactly 3 cycles after the ISSUE edge.
- rst_n pulsed low during WAIT → mem_en and acks are 0 immediately; no ack afterward; a reissued request completes normally.
- ARB_PERF_EN, 10 conflicting cycles as in scenario 3 → perf_conflicts equals the IDLE-conflict count and grant counters match the observed acks; without the macro, all perf_* read 0.
